// File: rtl/cpu_types_pkg.sv
// Basic CPU datapath types shared across the pipeline.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/pipe_types_pkg.sv
// Pipeline control enums: EX-stage branch kinds and PC source selects.
package pipe_types_pkg;
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_J    = 3'd3,
        BR_JR   = 3'd4
    } br_t;

    typedef br_t br_type_t;

    typedef enum logic [2:0] {
        PC_NEXT   = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_JR     = 3'd3
    } pcsrc_t;
endpackage

// File: rtl/flush_timer.sv
// Counts wait cycles of an outstanding redirect; expired marks the last
// permitted wait cycle so the caller can give up on that edge.
module flush_timer #(
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(FLUSH_TIMEOUT + 1);

    logic [W-1:0] count;

    assign expired = enable && (count == W'(FLUSH_TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != W'(FLUSH_TIMEOUT))) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution and PC redirect sequencing with flush timeout.
// Optional statistics counters enabled by macro BRANCH_STATS_EN.
//
// state    | meaning
// IDLE     | consuming EX instructions, PCsrc = PC_NEXT
// REDIRECT | PCsrc held, waiting for flush acknowledge or timeout
module branch_resolve_unit
    import cpu_types_pkg::*;
    import pipe_types_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ex_valid,
    input  br_type_t ex_br_type,
    input  word_t    rs_data,
    input  word_t    rt_data,
    input  logic     stall,
    input  logic     flushed,
    output logic     zero,
    output pcsrc_t   PCsrc,
    output logic     busy,
    output logic     flush_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] br_count,
    output logic [15:0] redirect_count
`endif
);
    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t state;
    pcsrc_t target;
    logic   ops_eq;
    logic   taken;
    logic   consume;
    logic   expired;

    assign ops_eq  = (rs_data == rt_data);
    assign consume = (state == IDLE) && ex_valid && !stall;
    assign busy    = (state == REDIRECT);

    always_comb begin
        taken  = 1'b0;
        target = PC_NEXT;
        case (ex_br_type)
            BR_BEQ:  begin taken = ops_eq;  target = PC_BRANCH; end
            BR_BNE:  begin taken = !ops_eq; target = PC_BRANCH; end
            BR_J:    begin taken = 1'b1;    target = PC_JUMP;   end
            BR_JR:   begin taken = 1'b1;    target = PC_JR;     end
            default: begin taken = 1'b0;    target = PC_NEXT;   end
        endcase
    end

    flush_timer #(.FLUSH_TIMEOUT(FLUSH_TIMEOUT)) u_flush_timer (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (state == IDLE),
        .enable  ((state == REDIRECT) && !flushed),
        .expired (expired)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            PCsrc     <= PC_NEXT;
            zero      <= 1'b0;
            flush_err <= 1'b0;
        end else begin
            flush_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (consume) begin
                        zero <= ops_eq;
                        if (taken) begin
                            PCsrc <= target;
                            state <= REDIRECT;
                        end
                    end
                end
                REDIRECT: begin
                    // acknowledge wins over a coincident timeout
                    if (flushed) begin
                        PCsrc <= PC_NEXT;
                        state <= IDLE;
                    end else if (expired) begin
                        flush_err <= 1'b1;
                        PCsrc     <= PC_NEXT;
                        state     <= IDLE;
                    end
                end
                default: begin
                    PCsrc <= PC_NEXT;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            br_count       <= '0;
            redirect_count <= '0;
        end else begin
            if (consume && ((ex_br_type == BR_BEQ) || (ex_br_type == BR_BNE))
                && (br_count != 16'hFFFF)) begin
                br_count <= br_count + 16'd1;
            end
            if (consume && taken && (redirect_count != 16'hFFFF)) begin
                redirect_count <= redirect_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed table, corner
// sequences, and randomized traffic against a behavioural model.
module tb_branch_resolve_unit;
    import cpu_types_pkg::*;
    import pipe_types_pkg::*;

    localparam int TO = 8;

    logic     CLK = 1'b0;
    logic     nRST;
    logic     ex_valid;
    br_type_t ex_br_type;
    word_t    rs_data, rt_data;
    logic     stall, flushed;
    logic     zero, busy, flush_err;
    pcsrc_t   PCsrc;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_count, redirect_count;
`endif

    int tot = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    branch_resolve_unit #(.FLUSH_TIMEOUT(TO)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ex_valid   (ex_valid),
        .ex_br_type (ex_br_type),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .stall      (stall),
        .flushed    (flushed),
        .zero       (zero),
        .PCsrc      (PCsrc),
        .busy       (busy),
        .flush_err  (flush_err)
`ifdef BRANCH_STATS_EN
        ,
        .br_count       (br_count),
        .redirect_count (redirect_count)
`endif
    );

    typedef struct {
        logic        valid;
        logic [2:0]  br;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        stl;
        logic        fl;
        int          pc;
        int          z;
        int          b;
        int          e;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        tot++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic v, input logic [2:0] br,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic stl, input logic fl);
        nRST       = rst_n;
        ex_valid   = v;
        ex_br_type = br_type_t'(br);
        rs_data    = rs;
        rt_data    = rt;
        stall      = stl;
        flushed    = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input int pc, input int z, input int b, input int e);
        chk({tag, ".PCsrc"}, int'(PCsrc), pc);
        chk({tag, ".zero"}, int'(zero), z);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".flush_err"}, int'(flush_err), e);
    endtask

    task automatic addv(input logic v, input logic [2:0] br, input logic [31:0] rs,
                        input logic [31:0] rt, input logic stl, input logic fl,
                        input int pc, input int z, input int b, input int e);
        vec_t t;
        t.valid = v; t.br = br; t.rs = rs; t.rt = rt; t.stl = stl; t.fl = fl;
        t.pc = pc; t.z = z; t.b = b; t.e = e;
        vecs.push_back(t);
    endtask

    // behavioural model state
    int  m_busy, m_pc, m_zero, m_err, m_wait;
    int  m_brc, m_rdc;

    task automatic model_step(input logic rst_n, input logic v, input logic [2:0] br,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic stl, input logic fl);
        int want_pc;
        if (!rst_n) begin
            m_busy = 0; m_pc = 0; m_zero = 0; m_err = 0; m_wait = 0;
            m_brc = 0; m_rdc = 0;
            return;
        end
        m_err = 0;
        if (m_busy == 0) begin
            if (v && !stl) begin
                m_zero  = (rs == rt) ? 1 : 0;
                want_pc = 0;
                if (br == 3'd1 && rs == rt) want_pc = 1;
                if (br == 3'd2 && rs != rt) want_pc = 1;
                if (br == 3'd3) want_pc = 2;
                if (br == 3'd4) want_pc = 3;
                if ((br == 3'd1 || br == 3'd2) && m_brc < 65535) m_brc++;
                if (want_pc != 0) begin
                    m_pc = want_pc; m_busy = 1; m_wait = 0;
                    if (m_rdc < 65535) m_rdc++;
                end
            end
        end else begin
            if (fl) begin
                m_busy = 0; m_pc = 0;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_err = 1; m_busy = 0; m_pc = 0;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] r1, r2;
        logic [2:0]  rb;
        logic        rv, rs_l, rf, rr;

        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_all("reset", 0, 0, 0, 0);

        //    v  br    rs             rt             stl fl   pc z b e
        addv(1, 3'd1, 32'h1234,      32'h1234,      0,  0,   1, 1, 1, 0);
        addv(0, 3'd0, 32'h0,         32'h0,         0,  0,   1, 1, 1, 0);
        addv(0, 3'd0, 32'h0,         32'h0,         0,  1,   0, 1, 0, 0);
        addv(1, 3'd2, 32'd5,         32'd5,         0,  0,   0, 1, 0, 0);
        addv(1, 3'd2, 32'd5,         32'd6,         0,  0,   1, 0, 1, 0);
        addv(1, 3'd1, 32'd9,         32'd9,         0,  1,   0, 0, 0, 0);
        addv(1, 3'd3, 32'd0,         32'd1,         0,  0,   2, 0, 1, 0);
        addv(1, 3'd4, 32'd3,         32'd3,         0,  0,   2, 0, 1, 0);
        addv(0, 3'd0, 32'd0,         32'd0,         0,  1,   0, 0, 0, 0);
        addv(0, 3'd0, 32'd0,         32'd0,         0,  1,   0, 0, 0, 0);
        addv(1, 3'd1, 32'd4,         32'd4,         1,  0,   0, 0, 0, 0);
        addv(0, 3'd1, 32'd4,         32'd4,         0,  0,   0, 0, 0, 0);
        addv(1, 3'd4, 32'd7,         32'd7,         0,  0,   3, 1, 1, 0);
        addv(0, 3'd0, 32'd0,         32'd0,         0,  1,   0, 1, 0, 0);
        addv(1, 3'd0, 32'd1,         32'd2,         0,  0,   0, 0, 0, 0);
        addv(1, 3'd1, 32'h8000_1234, 32'h0000_1234, 0,  0,   0, 0, 0, 0);
        addv(1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  0,   1, 1, 1, 0);
        addv(0, 3'd0, 32'd0,         32'd0,         0,  1,   0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].valid, vecs[i].br, vecs[i].rs, vecs[i].rt, vecs[i].stl, vecs[i].fl);
            chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].z, vecs[i].b, vecs[i].e);
        end

        // flush acknowledge never arrives: timeout on the 8th wait cycle
        drive(1'b1, 1'b1, 3'd3, 32'd1, 32'd1, 1'b0, 1'b0);
        chk_all("to_entry", 2, 1, 1, 0);
        for (int k = 1; k < TO; k++) begin
            drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            chk_all($sformatf("to_wait%0d", k), 2, 1, 1, 0);
        end
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_all("to_fire", 0, 1, 0, 1);
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_all("to_after", 0, 1, 0, 0);

        // acknowledge on the very cycle the timeout would fire
        drive(1'b1, 1'b1, 3'd3, 32'd1, 32'd2, 1'b0, 1'b0);
        chk_all("tf_entry", 2, 0, 1, 0);
        for (int k = 1; k < TO; k++) begin
            drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            chk_all($sformatf("tf_wait%0d", k), 2, 0, 1, 0);
        end
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk_all("tf_ack", 0, 0, 0, 0);
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_all("tf_after", 0, 0, 0, 0);

        // reset in the middle of a redirect
        drive(1'b1, 1'b1, 3'd4, 32'd8, 32'd8, 1'b0, 1'b0);
        chk_all("rr_entry", 3, 1, 1, 0);
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_all("rr_reset", 0, 0, 0, 0);

        // randomized traffic against the model
        model_step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            rr   = ($urandom_range(0, 59) != 0);
            rv   = ($urandom_range(0, 3) != 0);
            rb   = 3'($urandom_range(0, 7));
            r1   = $urandom;
            r2   = ($urandom_range(0, 1) != 0) ? r1 : ($urandom_range(0, 1) != 0 ? (r1 ^ (32'd1 << $urandom_range(0, 31))) : $urandom);
            rs_l = ($urandom_range(0, 3) == 0);
            rf   = ($urandom_range(0, 4) == 0);
            model_step(rr, rv, rb, r1, r2, rs_l, rf);
            drive(rr, rv, rb, r1, r2, rs_l, rf);
            chk_all($sformatf("rnd%0d", n), m_pc, m_zero, m_busy, m_err);
`ifdef BRANCH_STATS_EN
            chk($sformatf("rnd%0d.br_count", n), int'(br_count), m_brc);
            chk($sformatf("rnd%0d.redirect_count", n), int'(redirect_count), m_rdc);
`endif
        end

`ifdef BRANCH_STATS_EN
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("stats_reset_br", int'(br_count), 0);
        chk("stats_reset_rd", int'(redirect_count), 0);
        for (int n = 0; n < 70000; n++) begin
            drive(1'b1, 1'b1, 3'd1, 32'd3, 32'd3, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        end
        chk("stats_sat_br", int'(br_count), 16'hFFFF);
        chk("stats_sat_rd", int'(redirect_count), 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
